// File: rtl/chain_pulse_stimulus.sv
// Pulse-train driver and edge/latency capture for delay-chain evaluation.
// Drives a programmed pulse train, synchronizes the chain return and measures it.
module chain_pulse_stimulus #(
   parameter int CNT_W        = 16,
   parameter int NP_W         = 8,
   parameter int DRAIN_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] high_cycles,
   input  logic [CNT_W-1:0] low_cycles,
   input  logic [NP_W-1:0]  num_pulses,
   output logic             stim_out,
   input  logic             chain_in,
   output logic             busy,
   output logic             done,
   output logic [NP_W-1:0]  edge_count,
   output logic [CNT_W-1:0] latency,
   output logic             timeout
);

   typedef enum logic [2:0] {IDLE, HIGH, LOW, DRAIN, DONE} state_t;

   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
   localparam logic [NP_W-1:0]  ONE_N    = NP_W'(1);
   localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] h_cfg, l_cfg;
   logic [CNT_W-1:0] ph_cnt, ph_nxt;
   logic [NP_W-1:0]  np_cnt, np_nxt;
   logic [CNT_W-1:0] lat_cnt;
   logic             accept;
   logic             sync1, sync2, sync2_d;
   logic             edge_det;
   logic             seen;

   function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] v);
      return (v == '0) ? ONE_C : v;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc_c(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + ONE_C;
   endfunction

   function automatic logic [NP_W-1:0] sat_inc_n(input logic [NP_W-1:0] v);
      return (&v) ? v : v + ONE_N;
   endfunction

   // Next-state and phase/pulse counter decode; counters are loaded with length-1
   always_comb begin
      state_nxt = state;
      ph_nxt    = ph_cnt;
      np_nxt    = np_cnt;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (num_pulses == '0) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = HIGH;
                  ph_nxt    = eff_len(high_cycles) - ONE_C;
                  np_nxt    = num_pulses;
               end
            end
         end
         HIGH: begin
            if (ph_cnt == '0) begin
               state_nxt = LOW;
               ph_nxt    = eff_len(l_cfg) - ONE_C;
            end else begin
               ph_nxt = ph_cnt - ONE_C;
            end
         end
         LOW: begin
            if (ph_cnt == '0) begin
               if (np_cnt == ONE_N) begin
                  state_nxt = DRAIN;
                  ph_nxt    = DRAIN_LD;
               end else begin
                  state_nxt = HIGH;
                  np_nxt    = np_cnt - ONE_N;
                  ph_nxt    = eff_len(h_cfg) - ONE_C;
               end
            end else begin
               ph_nxt = ph_cnt - ONE_C;
            end
         end
         DRAIN: begin
            if (ph_cnt == '0) state_nxt = DONE;
            else              ph_nxt    = ph_cnt - ONE_C;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ph_cnt   <= '0;
         np_cnt   <= '0;
         h_cfg    <= '0;
         l_cfg    <= '0;
         stim_out <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         ph_cnt   <= ph_nxt;
         np_cnt   <= np_nxt;
         stim_out <= (state_nxt == HIGH);
         busy     <= (state_nxt == HIGH) || (state_nxt == LOW) || (state_nxt == DRAIN);
         done     <= (state_nxt == DONE);
         if (accept) begin
            h_cfg <= high_cycles;
            l_cfg <= low_cycles;
         end
      end
   end

   // Two-flop synchronizer plus one delay tap for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         sync2_d <= 1'b0;
      end else begin
         sync1   <= chain_in;
         sync2   <= sync1;
         sync2_d <= sync2;
      end
   end

   assign edge_det = sync2 ^ sync2_d;

   // Capture: lat_cnt reads 0 in the first stim_out-high cycle; an empty run reports timeout at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_count <= '0;
         latency    <= '0;
         timeout    <= 1'b0;
         lat_cnt    <= '0;
         seen       <= 1'b0;
      end else if (accept) begin
         edge_count <= '0;
         lat_cnt    <= '0;
         seen       <= 1'b0;
         if (num_pulses == '0) begin
            timeout <= 1'b1;
            latency <= '1;
         end else begin
            timeout <= 1'b0;
            latency <= '0;
         end
      end else if (busy) begin
         lat_cnt <= sat_inc_c(lat_cnt);
         if (edge_det) begin
            edge_count <= sat_inc_n(edge_count);
            if (!seen) begin
               seen    <= 1'b1;
               latency <= lat_cnt;
            end
         end
         if ((state == DRAIN) && (state_nxt == DONE) && !seen && !edge_det) begin
            timeout <= 1'b1;
            latency <= '1;
         end
      end
   end

endmodule

// File: tb/tb_chain_pulse_stimulus.sv
// Scoreboard bench for chain_pulse_stimulus: directed runs against loopback,
// tied-low and 5-cycle delayed chain models.
module tb_chain_pulse_stimulus;

   localparam int CNT_W        = 16;
   localparam int NP_W         = 8;
   localparam int DRAIN_CYCLES = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [CNT_W-1:0] high_cycles;
   logic [CNT_W-1:0] low_cycles;
   logic [NP_W-1:0]  num_pulses;
   logic             stim_out;
   logic             chain_in;
   logic             busy;
   logic             done;
   logic [NP_W-1:0]  edge_count;
   logic [CNT_W-1:0] latency;
   logic             timeout;

   chain_pulse_stimulus #(
      .CNT_W(CNT_W), .NP_W(NP_W), .DRAIN_CYCLES(DRAIN_CYCLES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .high_cycles(high_cycles), .low_cycles(low_cycles), .num_pulses(num_pulses),
      .stim_out(stim_out), .chain_in(chain_in), .busy(busy), .done(done),
      .edge_count(edge_count), .latency(latency), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Chain models: 0 tied low, 1 direct loopback, 2 five-cycle delay line
   int         mode = 0;
   logic [4:0] dly;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) dly <= '0;
      else        dly <= {dly[3:0], stim_out};
   end
   always_comb begin
      chain_in = 1'b0;
      case (mode)
         1:       chain_in = stim_out;
         2:       chain_in = dly[4];
         default: chain_in = 1'b0;
      endcase
   end

   typedef struct {
      int c0; int done_rel; int ec; int lat; int to; int busy_n; int stim_n; int first;
   } exp_t;
   exp_t sbq[$];

   int asserts = 0;
   int fails   = 0;

   task automatic chk(input string name, input int act, input int req);
      asserts++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Monitor: accumulates per-run activity and checks each done against the queue head
   int busy_n = 0, stim_n = 0, first = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_n = 0; stim_n = 0; first = 0;
         end else begin
            if (busy) busy_n++;
            if (stim_out) begin
               stim_n++;
               if (first == 0 && sbq.size() > 0) first = cyc - sbq[0].c0;
            end
            if (done) begin
               if (sbq.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  exp_t e;
                  e = sbq.pop_front();
                  chk("done_cycle", cyc - e.c0, e.done_rel);
                  chk("edge_count", int'(edge_count), e.ec);
                  chk("latency", int'(latency), e.lat);
                  chk("timeout", int'(timeout), e.to);
                  chk("busy_cycles", busy_n, e.busy_n);
                  chk("stim_high_cycles", stim_n, e.stim_n);
                  chk("first_stim_cycle", first, e.first);
               end
               busy_n = 0; stim_n = 0; first = 0;
            end
         end
      end
   end

   // Called at a negedge (cycle 0); returns at the negedge of cycle 1 with start low
   task automatic launch(input int h, input int l, input int n, input bit push,
                         input int done_rel, input int ec, input int lat, input int to,
                         input int bn, input int sn, input int fs);
      exp_t e;
      high_cycles = CNT_W'(h);
      low_cycles  = CNT_W'(l);
      num_pulses  = NP_W'(n);
      start       = 1'b1;
      e.c0 = cyc; e.done_rel = done_rel; e.ec = ec; e.lat = lat; e.to = to;
      e.busy_n = bn; e.stim_n = sn; e.first = fs;
      if (push) sbq.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (sbq.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         chk("run_completed_in_budget", 0, 1);
         sbq.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0;
      high_cycles = '0; low_cycles = '0; num_pulses = '0;
      repeat (3) @(negedge clk);
      chk("rst_stim_out", int'(stim_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_edge_count", int'(edge_count), 0);
      chk("rst_latency", int'(latency), 0);
      chk("rst_timeout", int'(timeout), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Loopback H=3 L=2 N=4: 8 edges, sync latency 2, done at 1+4*5+8
      mode = 1;
      launch(3, 2, 4, 1'b1, 29, 8, 2, 0, 28, 12, 1);
      wait_done(60);

      // Tied low H=1 L=1 N=2: no edges, timeout
      mode = 0;
      launch(1, 1, 2, 1'b1, 13, 0, 'hFFFF, 1, 12, 2, 1);
      wait_done(40);

      // Empty run: done at cycle 1, never busy
      launch(5, 5, 0, 1'b1, 1, 0, 'hFFFF, 1, 0, 0, 0);
      wait_done(10);

      // Mid-run start and config changes ignored; start while in DONE ignored
      mode = 1;
      launch(2, 1, 3, 1'b1, 18, 6, 2, 0, 17, 6, 1);
      start = 1'b1; high_cycles = 7; low_cycles = 7; num_pulses = 9;
      @(negedge clk);
      start = 1'b0;
      repeat (16) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done_ignored", int'(busy), 0);
      wait_done(20);

      // Reset while in HIGH aborts the run with no done
      launch(4, 4, 3, 1'b0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("busy_before_abort", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_stim_out", int'(stim_out), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_edge_count", int'(edge_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("no_done_after_abort", int'(done), 0);
      end

      // Zero phase lengths treated as 1: single-cycle high pulse
      launch(0, 0, 1, 1'b1, 11, 2, 2, 0, 10, 1, 1);
      wait_done(30);

      // Five-cycle delay, N=200 H=L=1: 400 edges saturate the 8-bit counter at 255; latency 2+5
      mode = 2;
      launch(1, 1, 200, 1'b1, 409, 255, 7, 0, 408, 200, 1);
      wait_done(500);

      chk("scoreboard_drained", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
